imm_extend_pipe: RTL and testbench
==================================

// Module: imm_extend_pipe
// PURPOSE
//  Registered, handshaked immediate generator for the decode stage. Takes instr[31:7] and an
//  ImmSrc select, builds the sign/zero-extended immediate at XLEN bits, and passes a tag through.
//  Results go into a 2-entry skid buffer, so decode can stall without dropping work.
//  Illegal selects are flagged and never produce X. Sits between fetch/decode and the execute register.
// PARAMETERS
//  XLEN   32  immediate width; 32 or 64 only; all formats sign-extend from instr[31] up to XLEN
//  TAG_W  5   width of the opaque side-band tag (rd/PC index) that travels with the immediate
// PORTS
//  clk          in   1       single clock; every register updates on posedge
//  reset        in   1       synchronous, active-high
//  in_valid     in   1       producer offers instr/imm_src/tag
//  in_ready     out  1       buffer can accept; push = in_valid & in_ready
//  in_instr     in   25      instruction bits [31:7]
//  in_imm_src   in   3       000 I, 001 S, 010 B, 011 J, 100 U, 101 Z (macro), others illegal
//  in_tag       in   TAG_W   side-band, returned unchanged with its result
//  out_valid    out  1       head entry valid
//  out_ready    in   1       consumer accepts; pop = out_valid & out_ready
//  out_imm      out  XLEN    immediate of the head entry
//  out_tag      out  TAG_W   tag of the head entry
//  out_illegal  out  1       head entry had an unsupported imm_src
// BEHAVIOUR
//  - Formats (s = instr[31] replicated to XLEN):
//    I {s,instr[30:20]}; S {s,instr[30:25],instr[11:7]}; B {s,instr[7],instr[30:25],instr[11:8],0};
//    J {s,instr[19:12],instr[20],instr[30:21],0}; U {s,instr[30:12],12'b0}.
//  - Illegal select: imm = 0, illegal = 1. Legal select: illegal = 0.
//  - Extension is combinational on the input side. The result, tag and illegal flag are written
//    into a 2-entry FIFO (head/tail pointers plus a 0..2 count).
//  - Latency: push at edge N gives out_valid = 1 from cycle N+1. No same-cycle bypass.
//  - in_ready = (count != 2). It is a function of registered state only and never depends on
//    in_valid or out_ready.
//  - Count update: push only +1; pop only -1; push and pop together leaves count unchanged, and the
//    entries stay in order.
//  - Full (count 2): in_ready = 0, and any input offered is ignored. A pop that cycle makes in_ready
//    = 1 on the next cycle.
//  - Empty (count 0): out_valid = 0. out_imm, out_tag and out_illegal hold their last values; they
//    are don't-care for the consumer.
//  - While out_valid & !out_ready, out_imm, out_tag and out_illegal stay stable.
//  - Pointers wrap modulo 2.
//  - Reset, including in the middle of a transfer: count, head and tail go to 0, and every entry is
//    cleared. Next cycle: out_valid = 0, out_imm = 0, out_tag = 0, out_illegal = 0, in_ready = 1.
//    A push presented in the reset cycle is discarded.
// CONFIGURATION
//  IMM_EXTEND_ZIMM_EN defined: imm_src 101 = Z-type CSR immediate, {(XLEN-5)'b0, instr[19:15]}, illegal = 0.
//  IMM_EXTEND_ZIMM_EN undefined: 101 is illegal (imm = 0, illegal = 1). Nothing else changes.
// TESTING
//  1. XLEN=32, push instr 0xFFF00093>>7 with src 000, out_ready=1 -> next cycle out_valid=1,
//     out_imm=0xFFFFFFFF, illegal=0.
//  2. Push 0xFE000EE3>>7 with src 010, tag 5'h0A -> out_imm=0xFFFFFFFC, out_tag=0x0A.
//  3. out_ready=0, three back-to-back pushes (I, S, U) -> in_ready drops after the 2nd; the 3rd is
//     held by the producer. Set out_ready=1 -> I, S, U pop in order with no loss or duplicate.
//  4. XLEN=64, push 0x800000B7>>7 with src 100 -> out_imm=0xFFFFFFFF80000000.
//  5. src 111 -> imm=0, illegal=1. src 101 on csrrwi with instr[19:15]=0x1F -> imm=0x1F with the
//     macro; imm=0, illegal=1 without it.
//  6. Fill to count 2, assert reset for one cycle with in_valid=1 -> next cycle out_valid=0,
//     in_ready=1, all outputs 0, no entry survives.

Source files
------------

// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: decode-side immediate generator feeding a 2-entry skid FIFO.
// Define IMM_EXTEND_ZIMM_EN to decode imm_src 101 as the CSR zimm immediate.
module imm_extend_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [24:0]      in_instr,
    input  logic [2:0]       in_imm_src,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [TAG_W-1:0] tag;
        logic             illegal;
    } entry_t;

    localparam logic [2:0] SRC_I = 3'b000;
    localparam logic [2:0] SRC_S = 3'b001;
    localparam logic [2:0] SRC_B = 3'b010;
    localparam logic [2:0] SRC_J = 3'b011;
    localparam logic [2:0] SRC_U = 3'b100;
`ifdef IMM_EXTEND_ZIMM_EN
    localparam logic [2:0] SRC_Z = 3'b101;
`endif

    entry_t     ext;
    entry_t     mem_q [2];
    entry_t     mem_n [2];
    entry_t     head_q;
    logic       hd_q;
    logic       hd_n;
    logic       tl_q;
    logic       tl_n;
    logic [1:0] cnt_q;
    logic [1:0] cnt_n;
    logic       push;
    logic       pop;
    logic       sgn;

    // in_instr[k] holds instruction bit k+7
    assign sgn = in_instr[24];

    always_comb begin
        ext     = '0;
        ext.tag = in_tag;
        unique case (in_imm_src)
            SRC_I: ext.imm = {{(XLEN-11){sgn}}, in_instr[23:13]};
            SRC_S: ext.imm = {{(XLEN-11){sgn}}, in_instr[23:18], in_instr[4:0]};
            SRC_B: ext.imm = {{(XLEN-12){sgn}}, in_instr[0], in_instr[23:18],
                              in_instr[4:1], 1'b0};
            SRC_J: ext.imm = {{(XLEN-20){sgn}}, in_instr[12:5], in_instr[13],
                              in_instr[23:14], 1'b0};
            SRC_U: ext.imm = {{(XLEN-31){sgn}}, in_instr[23:5], 12'b0};
`ifdef IMM_EXTEND_ZIMM_EN
            SRC_Z: ext.imm = {{(XLEN-5){1'b0}}, in_instr[12:8]};
`endif
            default: ext.illegal = 1'b1;
        endcase
    end

    assign in_ready  = (cnt_q != 2'd2);
    assign out_valid = (cnt_q != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        mem_n[0] = mem_q[0];
        mem_n[1] = mem_q[1];
        if (push) mem_n[tl_q] = ext;
        hd_n = hd_q ^ pop;
        tl_n = tl_q ^ push;
        unique case ({push, pop})
            2'b10:   cnt_n = cnt_q + 2'd1;
            2'b01:   cnt_n = cnt_q - 2'd1;
            default: cnt_n = cnt_q;
        endcase
    end

    // Output register tracks the next head; it holds when the FIFO drains.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            head_q   <= '0;
            hd_q     <= 1'b0;
            tl_q     <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            mem_q[0] <= mem_n[0];
            mem_q[1] <= mem_n[1];
            hd_q     <= hd_n;
            tl_q     <= tl_n;
            cnt_q    <= cnt_n;
            if (cnt_n != 2'd0) head_q <= mem_n[hd_n];
        end
    end

    assign out_imm     = head_q.imm;
    assign out_tag     = head_q.tag;
    assign out_illegal = head_q.illegal;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Scoreboard bench for imm_extend_pipe; drives XLEN=32 and XLEN=64 copies
// with identical stimulus and checks both against hand-computed immediates.
module tb_imm_extend_pipe;

    typedef struct {
        logic [63:0] imm;
        logic [4:0]  tag;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [24:0] in_instr = '0;
    logic [2:0]  in_imm_src = '0;
    logic [4:0]  in_tag = '0;
    logic        out_ready = 1'b0;

    logic        r32, v32, i32;
    logic [31:0] m32;
    logic [4:0]  t32;
    logic        r64, v64, i64;
    logic [63:0] m64;
    logic [4:0]  t64;

    exp_t q32[$];
    exp_t q64[$];
    int   compared = 0;
    int   mismatched = 0;

    imm_extend_pipe #(.XLEN(32), .TAG_W(5)) dut32 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(r32),
        .in_instr(in_instr), .in_imm_src(in_imm_src), .in_tag(in_tag),
        .out_valid(v32), .out_ready(out_ready), .out_imm(m32),
        .out_tag(t32), .out_illegal(i32)
    );

    imm_extend_pipe #(.XLEN(64), .TAG_W(5)) dut64 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(r64),
        .in_instr(in_instr), .in_imm_src(in_imm_src), .in_tag(in_tag),
        .out_valid(v64), .out_ready(out_ready), .out_imm(m64),
        .out_tag(t64), .out_illegal(i64)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset && v32 && out_ready) begin
            compared++;
            if (q32.size() == 0) begin
                mismatched++;
                $display("FAIL pop32_unexpected got imm=%h tag=%h", m32, t32);
            end else begin
                exp_t e;
                e = q32.pop_front();
                if (m32 !== e.imm[31:0] || t32 !== e.tag || i32 !== e.ill) begin
                    mismatched++;
                    $display("FAIL pop32 got imm=%h tag=%h ill=%b want imm=%h tag=%h ill=%b",
                             m32, t32, i32, e.imm[31:0], e.tag, e.ill);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && v64 && out_ready) begin
            compared++;
            if (q64.size() == 0) begin
                mismatched++;
                $display("FAIL pop64_unexpected got imm=%h tag=%h", m64, t64);
            end else begin
                exp_t e;
                e = q64.pop_front();
                if (m64 !== e.imm || t64 !== e.tag || i64 !== e.ill) begin
                    mismatched++;
                    $display("FAIL pop64 got imm=%h tag=%h ill=%b want imm=%h tag=%h ill=%b",
                             m64, t64, i64, e.imm, e.tag, e.ill);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        compared++;
        if (act !== want) begin
            mismatched++;
            $display("FAIL %s got %h want %h", name, act, want);
        end
    endtask

    task automatic send(input logic [31:0] ins, input logic [2:0] src,
                        input logic [4:0] tag, input logic [63:0] imm, input logic ill);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        in_valid   = 1'b1;
        in_instr   = ins[31:7];
        in_imm_src = src;
        in_tag     = tag;
        while (!r32 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!r32) begin
            compared++;
            mismatched++;
            $display("FAIL send_timeout got in_ready=0 want 1");
        end else begin
            e.imm = imm;
            e.tag = tag;
            e.ill = ill;
            q32.push_back(e);
            if (r64) q64.push_back(e);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q32.size() != 0 || q64.size() != 0) && n < 50) begin
            @(posedge clk);
            n++;
        end
        chk("drain32", 64'(q32.size()), 64'd0);
        chk("drain64", 64'(q64.size()), 64'd0);
    endtask

    logic [63:0] z_imm;
    logic        z_ill;

    initial begin
`ifdef IMM_EXTEND_ZIMM_EN
        z_imm = 64'h1F;
        z_ill = 1'b0;
`else
        z_imm = 64'h0;
        z_ill = 1'b1;
`endif
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_valid32", {63'd0, v32}, 64'd0);
        chk("rst_ready32", {63'd0, r32}, 64'd1);
        chk("rst_imm64", m64, 64'd0);
        chk("rst_ready64", {63'd0, r64}, 64'd1);

        // single transfers, consumer always ready
        #1 out_ready = 1'b1;
        send(32'hFFF00093, 3'b000, 5'h01, 64'hFFFFFFFFFFFFFFFF, 1'b0);
        @(negedge clk);
        chk("lat_valid32", {63'd0, v32}, 64'd1);
        send(32'hFE000EE3, 3'b010, 5'h0A, 64'hFFFFFFFFFFFFFFFC, 1'b0);
        send(32'h800000B7, 3'b100, 5'h02, 64'hFFFFFFFF80000000, 1'b0);
        send(32'hFFDFF06F, 3'b011, 5'h03, 64'hFFFFFFFFFFFFFFFC, 1'b0);
        send(32'hFFFFFFFF, 3'b111, 5'h04, 64'h0, 1'b1);
        send(32'hFFFFFFFF, 3'b110, 5'h05, 64'h0, 1'b1);
        send(32'h340FD073, 3'b101, 5'h06, z_imm, z_ill);
        drain();

        // back-pressure: two fill the buffer, the third waits
        @(posedge clk);
        #1 out_ready = 1'b0;
        send(32'h00500093, 3'b000, 5'h11, 64'h5, 1'b0);
        send(32'hFE102C23, 3'b001, 5'h12, 64'hFFFFFFFFFFFFFFF8, 1'b0);
        @(negedge clk);
        chk("full_ready32", {63'd0, r32}, 64'd0);
        chk("full_ready64", {63'd0, r64}, 64'd0);
        chk("stall_imm32", {32'd0, m32}, 64'h5);
        fork
            send(32'h12345037, 3'b100, 5'h13, 64'h12345000, 1'b0);
            begin
                repeat (3) @(posedge clk);
                chk("stall_hold64", m64, 64'h5);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // reset while full with a push offered
        @(posedge clk);
        #1 out_ready = 1'b0;
        send(32'hFFF00093, 3'b000, 5'h1F, 64'hFFFFFFFFFFFFFFFF, 1'b0);
        send(32'hFE102C23, 3'b001, 5'h1E, 64'hFFFFFFFFFFFFFFF8, 1'b0);
        reset      = 1'b1;
        in_valid   = 1'b1;
        in_instr   = 25'h1FFFFFF;
        in_imm_src = 3'b000;
        in_tag     = 5'h1D;
        @(posedge clk);
        #1 reset = 1'b0;
        in_valid = 1'b0;
        q32.delete();
        q64.delete();
        @(negedge clk);
        chk("mr_valid32", {63'd0, v32}, 64'd0);
        chk("mr_ready32", {63'd0, r32}, 64'd1);
        chk("mr_imm32", {32'd0, m32}, 64'd0);
        chk("mr_tag32", {59'd0, t32}, 64'd0);
        chk("mr_ill32", {63'd0, i32}, 64'd0);
        chk("mr_valid64", {63'd0, v64}, 64'd0);
        chk("mr_imm64", m64, 64'd0);
        chk("mr_tag64", {59'd0, t64}, 64'd0);
        #1 out_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("mr_empty32", {63'd0, v32}, 64'd0);
        chk("mr_empty64", {63'd0, v64}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
